// File: rtl/vga_fb_scanout_arb.sv
// Framebuffer scanout controller and single-port pixel RAM arbiter.
// Optional front/back buffer swapping: define VGA_FB_DOUBLE_BUFFER_EN.
module vga_fb_scanout_arb #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 4,
    parameter int PPW      = 4,
    parameter int FB_WORDS = 76800,
    parameter int ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   draw,
    input  logic                   hs_in,
    input  logic                   vs_in,
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    input  logic                   swap_req,
    output logic                   swap_done,
`endif
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [BPP*PPW-1:0]     wr_data,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_we,
    output logic [BPP*PPW-1:0]     mem_wdata,
    input  logic [BPP*PPW-1:0]     mem_rdata,
    output logic [BPP-1:0]         pixel,
    output logic                   pix_draw,
    output logic                   hs_out,
    output logic                   vs_out
);

    localparam int DW      = BPP * PPW;
    localparam int LOG_PPW = $clog2(PPW);
    localparam logic [ADDR_W-1:0] BACK_BASE = ADDR_W'(FB_WORDS);

    logic              fetch_slot;
    logic              wr_fire;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] wbase;
    logic              front_sel;

    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic [1:0]        fetch_pipe_q, fetch_pipe_d;
    logic [2:0]        draw_pipe_q, draw_pipe_d;
    logic [2:0]        hs_pipe_q, hs_pipe_d;
    logic [2:0]        vs_pipe_q, vs_pipe_d;

    // Every PPW-th active pixel owns the memory; all other cycles go to the writer.
    assign fetch_slot = draw && (x < 10'(H_ACTIVE)) && (x[LOG_PPW-1:0] == '0);
    assign wr_ready   = !rst && !fetch_slot;
    assign wr_fire    = wr_valid && wr_ready;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic front_sel_q, front_sel_d;
    logic pending_q, pending_d;
    logic swap_now;

    assign swap_now  = pending_q && (y == 10'(V_ACTIVE)) && (x == '0);
    assign swap_done = swap_now;
    assign front_sel = front_sel_q;

    // Latch swap requests and flip buffers at the start of vertical blanking.
    always_comb begin
        pending_d   = pending_q || swap_req;
        front_sel_d = front_sel_q;
        if (swap_now) begin
            pending_d   = 1'b0;
            front_sel_d = !front_sel_q;
        end
    end

    // Swap state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
        end
    end

    assign base  = front_sel ? BACK_BASE : '0;
    assign wbase = front_sel ? '0 : BACK_BASE;
`else
    assign front_sel = 1'b0;
    assign base      = front_sel ? BACK_BASE : '0;
    assign wbase     = base;
`endif

    // Memory port arbitration: fetch wins, else an accepted write, else idle.
    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (fetch_slot) begin
            mem_addr_d  = base + fetch_ptr_q;
            fetch_ptr_d = fetch_ptr_q + 1'b1;
        end else if (wr_fire) begin
            mem_addr_d  = wbase + wr_addr;
            mem_we_d    = 1'b1;
            mem_wdata_d = wr_data;
        end
        if (y >= 10'(V_ACTIVE)) begin
            fetch_ptr_d = '0;
        end
    end

    // Pixel serialiser and 3-stage sync/draw alignment pipeline.
    always_comb begin
        fetch_pipe_d = {fetch_pipe_q[0], fetch_slot};
        draw_pipe_d  = {draw_pipe_q[1:0], draw};
        hs_pipe_d    = {hs_pipe_q[1:0], hs_in};
        vs_pipe_d    = {vs_pipe_q[1:0], vs_in};
        if (fetch_pipe_q[1]) begin
            shreg_d = mem_rdata;
        end else begin
            shreg_d = shreg_q >> BPP;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ptr_q  <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            shreg_q      <= '0;
            fetch_pipe_q <= '0;
            draw_pipe_q  <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
        end else begin
            fetch_ptr_q  <= fetch_ptr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            shreg_q      <= shreg_d;
            fetch_pipe_q <= fetch_pipe_d;
            draw_pipe_q  <= draw_pipe_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_draw  = draw_pipe_q[2];
    assign hs_out    = hs_pipe_q[2];
    assign vs_out    = vs_pipe_q[2];
    assign pixel     = draw_pipe_q[2] ? shreg_q[BPP-1:0] : '0;

endmodule

// File: tb/tb_vga_fb_scanout_arb.sv
// Scoreboard bench for vga_fb_scanout_arb on a reduced-size raster.
// Reference model works on pixel coordinates and a word-array image.
module tb_vga_fb_scanout_arb;

    localparam int H_ACT = 32;
    localparam int V_ACT = 6;
    localparam int H_TOT = 40;
    localparam int V_TOT = 9;
    localparam int HS_S  = 34;
    localparam int HS_E  = 37;
    localparam int VS_Y  = 7;
    localparam int BPP   = 4;
    localparam int PPW   = 4;
    localparam int FBW   = (H_ACT * V_ACT) / PPW;
    localparam int AW    = 8;
    localparam int DW    = BPP * PPW;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    localparam int WB    = FBW;
`else
    localparam int WB    = 0;
`endif

    typedef struct {
        logic           d;
        logic           h;
        logic           v;
        logic [BPP-1:0] p;
        bit             cp;
    } pe_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ca;
        bit            cd;
    } me_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [9:0]     x = '0;
    logic [9:0]     y = '0;
    logic           draw = 1'b0;
    logic           hs_in = 1'b1;
    logic           vs_in = 1'b1;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic [BPP-1:0] pixel;
    logic           pix_draw;
    logic           hs_out;
    logic           vs_out;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic           swap_req = 1'b0;
    logic           swap_done;
`endif

    int errors = 0;
    int checks = 0;

    pe_t pq[$];
    me_t mq[$];
    pe_t mp;
    me_t mm;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ref_ram [0:(1<<AW)-1];

    int            gx;
    int            gy;
    bit            synced;
    bit            prev_rst;
    bit            wpend;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] cur_word;

    vga_fb_scanout_arb #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .BPP      (BPP),
        .PPW      (PPW),
        .FB_WORDS (FBW),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .draw      (draw),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        .swap_req  (swap_req),
        .swap_done (swap_done),
`endif
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pixel     (pixel),
        .pix_draw  (pix_draw),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input bit r);
        bit  slot;
        bit  acc;
        int  idx;
        pe_t pe;
        me_t me;
        @(posedge clk);
        #1;
        rst = r;
        x = 10'(gx);
        y = 10'(gy);
        draw = (gx < H_ACT) && (gy < V_ACT);
        hs_in = !(gx >= HS_S && gx <= HS_E);
        vs_in = !(gy == VS_Y);
        if (r) begin
            pq.delete();
            mq.delete();
            synced = 0;
            wpend = 0;
        end else if (!wpend && $urandom_range(0, 2) == 0) begin
            wpend = 1;
            wa = AW'($urandom_range(0, FBW - 1));
            wd = DW'($urandom);
        end
        wr_valid = wpend;
        wr_addr = wa;
        wr_data = wd;
        slot = draw && (gx % PPW == 0);
        if (!r) begin
            if (prev_rst) begin
                pe = '{d: 1'b0, h: 1'b1, v: 1'b1, p: '0, cp: 1'b1};
                repeat (3) pq.push_back(pe);
                me = '{we: 1'b0, a: '0, d: '0, ca: 1'b1, cd: 1'b1};
                mq.push_back(me);
            end
            if (gy >= V_ACT) synced = 1;
            acc = wpend && !slot;
            idx = gy * (H_ACT / PPW) + gx / PPW;
            if (slot) cur_word = ref_ram[idx];
            pe.d = draw;
            pe.h = hs_in;
            pe.v = vs_in;
            pe.p = draw ? cur_word[(gx % PPW) * BPP +: BPP] : '0;
            pe.cp = !draw || synced;
            pq.push_back(pe);
            if (slot) begin
                me = '{we: 1'b0, a: AW'(idx), d: '0, ca: synced, cd: 1'b0};
            end else if (acc) begin
                me = '{we: 1'b1, a: AW'(WB + int'(wa)), d: wd, ca: 1'b1, cd: 1'b1};
            end else begin
                me = '{we: 1'b0, a: '0, d: '0, ca: 1'b0, cd: 1'b0};
            end
            mq.push_back(me);
            if (acc) begin
                ref_ram[WB + int'(wa)] = wd;
                wpend = 0;
            end
            #2;
            chk("wr_ready", {31'b0, wr_ready}, {31'b0, !slot});
        end else begin
            #2;
            chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        end
        prev_rst = r;
        gx++;
        if (gx == H_TOT) begin
            gx = 0;
            gy++;
            if (gy == V_TOT) gy = 0;
        end
    endtask

    // Monitor: reset values while in reset, else pop and compare the scoreboards.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pixel", {28'b0, pixel}, 32'd0);
            chk("rst_hs", {31'b0, hs_out}, 32'd1);
            chk("rst_vs", {31'b0, vs_out}, 32'd1);
            chk("rst_draw", {31'b0, pix_draw}, 32'd0);
            chk("rst_we", {31'b0, mem_we}, 32'd0);
        end else begin
            if (pq.size() > 3) begin
                mp = pq.pop_front();
                chk("pix_draw", {31'b0, pix_draw}, {31'b0, mp.d});
                chk("hs_out", {31'b0, hs_out}, {31'b0, mp.h});
                chk("vs_out", {31'b0, vs_out}, {31'b0, mp.v});
                if (mp.cp) chk("pixel", {28'b0, pixel}, {28'b0, mp.p});
            end
            if (mq.size() > 1) begin
                mm = mq.pop_front();
                chk("mem_we", {31'b0, mem_we}, {31'b0, mm.we});
                if (mm.ca) chk("mem_addr", {24'b0, mem_addr}, {24'b0, mm.a});
                if (mm.cd) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, mm.d});
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ref_ram[i] = DW'($urandom);
            ram[i] = ref_ram[i];
        end
        ref_ram[0] = 16'h4321;
        ram[0] = 16'h4321;
        cur_word = '0;
        synced = 0;
        wpend = 0;
        wa = '0;
        wd = '0;
        prev_rst = 1;
        gx = 20;
        gy = 2;
        #2 rst = 1'b1;
        repeat (5) step(1'b1);
        repeat (3 * H_TOT * V_TOT) step(1'b0);
        gx = 13;
        gy = 3;
        repeat (3) step(1'b1);
        repeat (2 * H_TOT * V_TOT + 50) step(1'b0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
